// File: rtl/br_rs_issue_queue_pkg.sv
// Shared types for the branch reservation station.
//   ptag_t            physical register tag
//   br_op_e           branch/jump micro-op kind
//   functional_unit_t payload handed to the branch unit
//   cdb_output_t      one common-data-bus result broadcast
//   br_rs_entry_t     one reservation-station slot (payload + source tracking)
package br_rs_issue_queue_pkg;

    localparam int BR_RS_DEPTH   = 8;
    localparam int BR_RS_NUM_CDB = 4;
    localparam int PTAG_W        = 6;
    localparam int XLEN          = 32;

    typedef logic [PTAG_W-1:0] ptag_t;

    typedef enum logic [1:0] {
        op_b_br   = 2'd0,
        op_b_jal  = 2'd1,
        op_b_jalr = 2'd2
    } br_op_e;

    typedef struct packed {
        br_op_e            op;
        logic [2:0]        funct3;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        ptag_t             phys_rd;
        logic [XLEN-1:0]   rs1_v;
        logic [XLEN-1:0]   rs2_v;
    } functional_unit_t;

    typedef struct packed {
        logic              valid;
        ptag_t             commit_phys_rd_addr;
        logic [XLEN-1:0]   data;
    } cdb_output_t;

    typedef struct packed {
        functional_unit_t  fu;
        ptag_t             rs1_tag;
        ptag_t             rs2_tag;
        logic              rs1_rdy;
        logic              rs2_rdy;
    } br_rs_entry_t;

endpackage

// File: rtl/br_rs_issue_queue_if.sv
// Bus between dispatch / CDB / branch unit and the reservation station.
//   master: dispatch_valid, dispatch_entry, cdb, flush, stall out;
//           rs_full, start, functional_br_unit, count in
//   slave : the reservation station side (directions mirrored)
interface br_rs_issue_queue_if
    import br_rs_issue_queue_pkg::*;
#(
    parameter int DEPTH   = BR_RS_DEPTH,
    parameter int NUM_CDB = BR_RS_NUM_CDB
) ();
    logic                   dispatch_valid;
    br_rs_entry_t           dispatch_entry;
    logic                   rs_full;
    cdb_output_t            cdb [NUM_CDB];
    logic                   flush;
    logic                   stall;
    logic                   start;
    functional_unit_t       functional_br_unit;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output dispatch_valid, dispatch_entry, cdb, flush, stall,
        input  rs_full, start, functional_br_unit, count
    );

    modport slave (
        input  dispatch_valid, dispatch_entry, cdb, flush, stall,
        output rs_full, start, functional_br_unit, count
    );
endinterface

// File: rtl/br_rs_oldest_ready_sel.sv
// Priority encoder: finds the lowest-index (oldest) set bit of the ready vector.
//   i_ready  per-entry ready flags, bit 0 = oldest
//   o_found  at least one entry is ready
//   o_idx    index of the oldest ready entry (0 when none)
module br_rs_oldest_ready_sel #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]         i_ready,
    output logic                     o_found,
    output logic [$clog2(DEPTH)-1:0] o_idx
);
    localparam int IDX_W = $clog2(DEPTH);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_found = |i_ready;
        o_idx   = '0;
        // Scan downward so the lowest ready index is the last one written.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_ready[i]) o_idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/br_rs_issue_queue.sv
// Age-ordered collapsing reservation station for branch/jump micro-ops.
//   clk, rst  clock, synchronous active-high reset
//   bus       slave side of br_rs_issue_queue_if: dispatch in, CDB snoop,
//             flush/stall in, registered start + payload out, rs_full/count out
module br_rs_issue_queue
    import br_rs_issue_queue_pkg::*;
#(
    parameter int DEPTH   = BR_RS_DEPTH,
    parameter int NUM_CDB = BR_RS_NUM_CDB
) (
    input  logic                clk,
    input  logic                rst,
    br_rs_issue_queue_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    br_rs_entry_t      r_entries [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic              r_start;
    functional_unit_t  r_fu;

    cdb_output_t       w_cdb    [NUM_CDB];
    br_rs_entry_t      w_woken  [DEPTH];
    br_rs_entry_t      w_next   [DEPTH];
    br_rs_entry_t      w_disp;
    logic [DEPTH-1:0]  w_ready;
    logic              w_found;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_full;
    logic              w_issue;
    logic              w_dispatch;
    logic [CNT_W-1:0]  w_count_next;

    // Capture any broadcast that matches a not-yet-ready source. Scanning k
    // upward and setting rdy on the first hit makes the lowest port win.
    function automatic br_rs_entry_t f_wake(input br_rs_entry_t e,
                                            input cdb_output_t  c [NUM_CDB]);
        for (int k = 0; k < NUM_CDB; k++) begin
            if (c[k].valid && !e.rs1_rdy && e.rs1_tag == c[k].commit_phys_rd_addr) begin
                e.rs1_rdy  = 1'b1;
                e.fu.rs1_v = c[k].data;
            end
            if (c[k].valid && !e.rs2_rdy && e.rs2_tag == c[k].commit_phys_rd_addr) begin
                e.rs2_rdy  = 1'b1;
                e.fu.rs2_v = c[k].data;
            end
        end
        return e;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) w_cdb[k] = bus.cdb[k];
    end

    // Ready comes only from registered state: a wakeup this cycle becomes
    // issue-eligible next cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = (CNT_W'(i) < r_count) && r_entries[i].rs1_rdy && r_entries[i].rs2_rdy;
        end
    end

    br_rs_oldest_ready_sel #(.DEPTH(DEPTH)) u_sel (
        .i_ready (w_ready),
        .o_found (w_found),
        .o_idx   (w_sel_idx)
    );

    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_issue      = w_found && !bus.stall && !bus.flush;
    assign w_dispatch   = bus.dispatch_valid && !w_full && !bus.flush;
    // After a collapse the free slot is one lower.
    assign w_wr_idx     = IDX_W'(r_count - CNT_W'(w_issue));
    assign w_count_next = r_count + CNT_W'(w_dispatch) - CNT_W'(w_issue);

    // Incoming entry: tag 0 is hard-wired ready, then same-cycle CDB bypass.
    always_comb begin
        w_disp = bus.dispatch_entry;
        if (w_disp.rs1_tag == '0) w_disp.rs1_rdy = 1'b1;
        if (w_disp.rs2_tag == '0) w_disp.rs2_rdy = 1'b1;
        w_disp = f_wake(w_disp, w_cdb);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) w_woken[i] = f_wake(r_entries[i], w_cdb);
        for (int i = 0; i < DEPTH; i++) w_next[i] = w_woken[i];
        // Collapse: everything at or above the issued slot moves down one.
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_issue && IDX_W'(i) >= w_sel_idx) w_next[i] = w_woken[i+1];
        end
        if (w_dispatch) w_next[w_wr_idx] = w_disp;
    end

    // NOTE: slot storage has no reset; r_count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        r_entries <= w_next;
    end

    // NOTE: all sequential state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_start <= 1'b0;
            r_fu    <= '0;
        end else if (bus.flush) begin
            // Payload is deliberately left as-is; only the pulse is cleared.
            r_count <= '0;
            r_start <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (!bus.stall) begin
                r_start <= w_issue;
                if (w_issue) r_fu <= r_entries[w_sel_idx].fu;
            end
        end
    end

    assign bus.rs_full            = w_full;
    assign bus.count              = r_count;
    assign bus.start              = r_start;
    assign bus.functional_br_unit = r_fu;
endmodule

// File: doc/br_rs_issue_queue.md
Name: br_rs_issue_queue

Overview:
- Reservation station for branch and jump µops (op_b_br, op_b_jal, op_b_jalr), sitting between dispatch/rename and the branch functional unit.
- Holds up to DEPTH µops in an age-ordered collapsing queue and captures source operands from CDB broadcasts.
- Each cycle it issues the oldest fully-ready µop to the branch unit as a registered start pulse plus a functional_unit_t payload, and honours the downstream stall.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- NUM_CDB, 4, number of CDB broadcast ports snooped for wakeup.
- PTAG_W, 6, physical register tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dispatch_valid  in  1  new µop presented this cycle
- dispatch_entry  in  br_rs_entry_t  µop payload, source tags and initial ready bits
- rs_full  out  1  no free entry; dispatch is refused while high
- cdb  in  cdb_output_t [NUM_CDB]  result broadcasts (valid, commit_phys_rd_addr, data)
- flush  in  1  mispredict recovery; discard all entries
- stall  in  1  branch unit cannot accept; hold issue outputs
- start  out  1  one-cycle issue pulse to the branch unit
- functional_br_unit  out  functional_unit_t  issued payload; valid while start is high
- count  out  $clog2(DEPTH)+1  occupied entries, for debug and perf

Behaviour:
- Reset: all entries invalid; count=0; rs_full=0; start=0; functional_br_unit='0.
- Storage: entry 0 is the oldest; valid entries are contiguous from index 0. Each entry holds the payload plus rs1_tag, rs2_tag, rs1_rdy, rs2_rdy.
- Tag 0 is always ready. Dispatch forces rdy=1 when the tag is 0.
- Wakeup, every cycle: for each valid entry and each cdb[k] with valid=1, if tag==commit_phys_rd_addr and rdy==0, then rdy<=1 and the value is written from data. Lower k wins on duplicate tags; legal traffic never produces them.
- Same-cycle bypass: a CDB match against dispatch_entry tags in the dispatch cycle sets rdy and value on the newly written entry.
- Readiness: an entry is ready iff valid && rs1_rdy && rs2_rdy. Wakeup seen in cycle N makes the entry issue-eligible at the earliest in cycle N+1 (no combinational wake-to-issue path).
- Issue when stall=0: select the lowest-index ready entry.
  - start<=1 and functional_br_unit<=entry payload with rs1_v/rs2_v filled from captured values.
  - Remove the entry; entries above it shift down by one.
  - If no entry is ready: start<=0.
- Issue when stall=1: start and functional_br_unit hold their current values; no selection; no removal.
- Dispatch: accepted iff dispatch_valid && !rs_full && !flush. It is written at index count, or count-1 if an issue removes an entry in the same cycle.
- rs_full = (count==DEPTH), decoded from registered state. Issue and dispatch in the same cycle at full still refuses the dispatch.
- count_next = count + accepted_dispatch - issued.
- flush: next cycle all entries are invalid, count=0, start=0, and functional_br_unit is unchanged. flush overrides dispatch, issue and wakeup that cycle. Flush while stall=1 still clears start.
- Latency: a dispatch with both sources ready at cycle N gives start=1 at the N+1 → N+2 boundary. Concretely, the entry is visible at N+1 and start is registered high from the N+1 edge.

Decomposition:
- module_types: add br_rs_entry_t, containing functional_unit_t fu, ptag rs1_tag, ptag rs2_tag, rs1_rdy, rs2_rdy. Add a typedef for the PTAG_W-wide tag.
- Sub-module br_rs_oldest_ready_sel: combinational priority encoder over the ready vector, returning a found bit and an index.
- Shift/collapse logic and wakeup comparators stay in the top module.

Test Plan:
- Reset then dispatch a jal with tags 0/0 at cycle 2, stall=0 → start=1 for exactly one cycle after the cycle-3 edge, payload pc matches, count returns to 0.
- Dispatch beq A (rs1_tag=5 not ready), then beq B (ready); cdb[2] broadcasts tag 5, data 32'h10, in cycle 6 → B issues first; A issues the cycle after wakeup with rs1_v=32'h10.
- Fill 8 ready entries with stall=1 → rs_full=1, 9th dispatch dropped, start/payload frozen. Release stall → 8 issues in age order on consecutive cycles, count 8→0.
- Dispatch with rs2_tag=9 while cdb[0] broadcasts tag 9, data 32'hABCD in the same cycle → entry issues next cycle with rs2_v=32'hABCD.
- Flush asserted with 5 entries, a simultaneous dispatch and stall=1 → next cycle count=0, start=0, dispatch not captured.
- At count=DEPTH with an issue and dispatch in the same cycle → dispatch refused, count=DEPTH-1.
